dmem_store_buffer: RTL
======================

# dmem_store_buffer

Data-memory responder for the core's load/store port (`wr`, `rd`, `addr`, `wr_data`, `rd_data`). It owns the 128-word data array and puts a coalescing store buffer in front of it. Stores retire into the buffer in one cycle. Loads are answered in the same cycle, with forwarding from the buffer. Buffered stores drain to the array, oldest first, whenever the array port is free or space is needed.

## Interface
Parameters:
- `DATA_W`, 32, data word width
- `ADDR_W`, 9, byte address width; word index is `addr[ADDR_W-1:2]`, giving 128 words
- `DEPTH`, 4, store buffer entries

Ports:
- `clk`  in  1  clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-high
- `wr`  in  1  store request, this cycle
- `rd`  in  1  load request, this cycle
- `addr`  in  ADDR_W  byte address; `addr[1:0]` ignored
- `wr_data`  in  DATA_W  store data
- `rd_data`  out  DATA_W  load data, combinational
- `flush`  in  1  level; while high, drain one entry per eligible cycle
- `buf_count`  out  3  valid buffer entries, 0..DEPTH
- `buf_empty`  out  1  `buf_count == 0`
- `drain_valid`  out  1  an entry is written to the array this cycle (combinational)
- `drain_addr`  out  7  word index being drained when `drain_valid` is high, else 0

## Operation
- **Storage**
  - Array: 128 x DATA_W, one access per cycle, either a load read or a drain write.
  - Buffer: DEPTH entries of {valid, word index, data}, kept in FIFO age order.
  - At most one valid entry exists per word index, guaranteed by coalescing.
- **Word index:** `widx = addr[8:2]`.
- **Load** (`rd=1`, `wr=0`)
  - Buffer hit on `widx`: `rd_data` is that entry's data.
  - Miss: `rd_data` is `array[widx]`.
  - No drain occurs in a load cycle.
  - When `rd=0`, `rd_data` is 0.
- **Store** (`wr=1`)
  - **Hit** (a valid entry matches `widx`): overwrite that entry's data in place. Its age position is kept and `buf_count` is unchanged. No forced drain.
  - **Miss, not full:** append at tail; `buf_count` +1.
  - **Miss, full:** drain the oldest entry to the array this cycle and append the new one at the tail. `buf_count` stays DEPTH.
- **Illegal input** (`rd=1` and `wr=1` together): the store is performed, the load is ignored, and `rd_data` is 0.
- **Drain eligibility:** a cycle drains when `buf_count>0`, `rd=0`, and any of the following holds:
  - the cycle is idle (`wr=0`);
  - `flush=1`;
  - a store misses while the buffer is full.
- **Drain action:** write the oldest entry to the array, invalidate it, and shift the remaining entries' age.
  - If a store also hits in that cycle and the hit entry is not the oldest, both actions occur.
  - If the hit entry is the oldest and is being drained, the store's data is written to the array instead and the entry is removed.
- **Reset**
  - All buffer entries are invalidated. Pending stores are discarded, not drained.
  - All 128 array words are cleared to 0.
  - Reset overrides any concurrent `rd`, `wr` or `flush`.

## Timing
- **Reset values:** `rd_data=0`, `buf_count=0`, `buf_empty=1`, `drain_valid=0`, `drain_addr=0`.
- **Load latency:** 0 cycles. `rd_data` is valid combinationally in the request cycle.
- **Store visibility:** a store in cycle N is visible to a load in cycle N+1 or later, whether it is forwarded or already drained. A load in the same cycle N sees the old value.
- **Drain timing:** a drain in cycle N updates the array at the edge ending N. `buf_count` reflects the drain in N+1.
- **Flush:** with `flush=1` and no loads, the buffer empties in `buf_count` cycles. `buf_empty` rises in the cycle after the last drain.
- **Idle drain:** an idle cycle drains exactly one entry, never more.

## Test plan
- **Reset state:** reset for 2 cycles, then read `addr=0x010` -> `rd_data=0`, `buf_count=0`, `buf_empty=1`.
- **Store then load:** write `0xDEADBEEF` to `0x020`, read `0x020` next cycle with no idle between -> `rd_data=0xDEADBEEF` (forwarded), `buf_count=1`. One idle cycle -> `drain_valid=1`, `drain_addr=8`. A later read returns the same value from the array.
- **Coalescing:** write `0x1` then `0x2` to `0x040` back-to-back -> `buf_count=1`, read `=0x2`. Then 1 idle cycle -> `buf_count=0`, array word 16 `=0x2`.
- **Full buffer:** 5 back-to-back stores to distinct words 0,4,8,12,16 with no idle cycles.
  - On the 5th store: `drain_valid=1`, `drain_addr=0`, `buf_count` stays 4.
  - Reads of all 5 addresses return their data.
- **Flush and reset**
  - Fill 3 entries, then assert `flush` with no loads -> 3 consecutive drains, then `buf_empty=1`.
  - Refill 2 entries, then assert `reset` -> `buf_count=0` and reads return 0.
- **Illegal rd+wr, and drain under load**
  - Simultaneous `rd=1`, `wr=1` to `0x004` with data `0x5` -> `rd_data=0`; the next-cycle read returns `0x5`.
  - Continuous loads with `buf_count=2` -> no drain until the first idle cycle.

Source files
------------

// File: rtl/dmem_store_buffer.sv
// Data-memory responder: 128-word array fronted by a coalescing FIFO store buffer.
// Loads answer combinationally with forwarding; buffered stores drain oldest first.
module dmem_store_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  input  logic              flush,
  output logic [2:0]        buf_count,
  output logic              buf_empty,
  output logic              drain_valid,
  output logic [6:0]        drain_addr
);
  localparam int IDX_W = ADDR_W - 2;
  localparam int WORDS = 1 << IDX_W;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Entry 0 is the oldest; entries [0, count) are valid, so no per-entry valid bit.
  logic [IDX_W-1:0]  ent_idx  [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [2:0]        count;
  logic [DATA_W-1:0] mem      [WORDS];

  logic [IDX_W-1:0]  widx;
  logic              hit;
  logic [PW-1:0]     hit_pos;
  logic              full;
  logic              load_op;
  logic              drain;
  logic [IDX_W-1:0]  nxt_idx  [DEPTH];
  logic [DATA_W-1:0] nxt_data [DEPTH];
  logic [2:0]        nxt_count;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              unused;

  assign unused  = ^addr[1:0];
  assign widx    = addr[ADDR_W-1:2];
  assign full    = (count == 3'(DEPTH));
  assign load_op = rd && !wr && !reset;

  always_comb begin
    hit     = 1'b0;
    hit_pos = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && (3'(i) < count) && (ent_idx[i] == widx)) begin
        hit     = 1'b1;
        hit_pos = PW'(i);
      end
    end
  end

  // A simultaneous rd+wr behaves as a store, so it may drain (needed when full).
  assign drain = !reset && (count != 3'd0) && !load_op &&
                 (!wr || flush || (wr && !hit && full));

  always_comb begin
    nxt_idx   = ent_idx;
    nxt_data  = ent_data;
    nxt_count = count;
    mem_we    = 1'b0;
    mem_waddr = ent_idx[0];
    mem_wdata = ent_data[0];
    if (drain) begin
      mem_we = 1'b1;
      for (int i = 0; i < DEPTH - 1; i++) begin
        nxt_idx[i]  = ent_idx[i+1];
        nxt_data[i] = ent_data[i+1];
      end
      nxt_count = count - 3'd1;
      if (wr && hit) begin
        // Hit on the entry leaving this cycle: the newer data goes straight to the array.
        if (hit_pos == '0) mem_wdata = wr_data;
        else nxt_data[hit_pos - PW'(1)] = wr_data;
      end else if (wr) begin
        nxt_idx[PW'(count - 3'd1)]  = widx;
        nxt_data[PW'(count - 3'd1)] = wr_data;
        nxt_count                  = count;
      end
    end else if (wr && !reset) begin
      if (hit) begin
        nxt_data[hit_pos] = wr_data;
      end else begin
        nxt_idx[PW'(count)]  = widx;
        nxt_data[PW'(count)] = wr_data;
        nxt_count            = count + 3'd1;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (load_op) begin
      rd_data = mem[widx];
      if (hit) rd_data = ent_data[hit_pos];
    end
  end

  assign buf_count   = count;
  assign buf_empty   = (count == 3'd0);
  assign drain_valid = drain;
  assign drain_addr  = drain ? 7'(ent_idx[0]) : 7'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_idx[i]  <= '0;
        ent_data[i] <= '0;
      end
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else begin
      count    <= nxt_count;
      ent_idx  <= nxt_idx;
      ent_data <= nxt_data;
      if (mem_we) mem[mem_waddr] <= mem_wdata;
    end
  end
endmodule
